// File: rtl/x448_pkg.sv
// rtl/x448_pkg.sv - shared x448 constants and sequencer state encoding
package x448_pkg;

    localparam int N448 = 448;

    // P448 = 2^448 - 2^224 - 1
    localparam logic [N448-1:0] P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [N448-1:0] ONE  = N448'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_REQ,
        S_SQ_WAIT,
        S_MUL_REQ,
        S_MUL_WAIT,
        S_NEXT,
        S_DONE
    } powmod_state_t;

endpackage

// File: rtl/powmod_seq.sv
// rtl/powmod_seq.sv - left-to-right square-and-multiply X^E mod P448 over an external multmod core
// Optional: POWMOD_SKIP_LEADING_ZEROS_EN skips leading exponent zeros and seeds acc with base.
module powmod_seq
    import x448_pkg::*;
#(
    parameter int N  = N448,
    parameter int EW = 448,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  X,
    input  logic [EW-1:0] E,
    input  logic          req_valid,
    output logic          req_ready,
    output logic          req_busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  Z,
    output logic [N-1:0]  mm_X,
    output logic [N-1:0]  mm_Y,
    output logic          mm_req_valid,
    input  logic          mm_req_ready,
    input  logic          mm_req_busy,
    input  logic          mm_res_valid,
    output logic          mm_res_ready,
    input  logic [N-1:0]  mm_Z,
    output logic [CW-1:0] op_count
);

    localparam int IW = (EW > 1) ? $clog2(EW) : 1;

    powmod_state_t state;
    logic [N-1:0]  acc;
    logic [N-1:0]  base;
    logic [EW-1:0] exp;
    logic [IW-1:0] idx;
    logic          unused_mm_busy;
`ifdef POWMOD_SKIP_LEADING_ZEROS_EN
    logic          lead;
`endif

    assign unused_mm_busy = mm_req_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            acc      <= '0;
            base     <= '0;
            exp      <= '0;
            idx      <= '0;
            op_count <= '0;
`ifdef POWMOD_SKIP_LEADING_ZEROS_EN
            lead     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        base     <= X;
                        exp      <= E;
                        acc      <= N'(ONE);
                        idx      <= IW'(EW - 1);
                        op_count <= '0;
`ifdef POWMOD_SKIP_LEADING_ZEROS_EN
                        lead     <= 1'b1;
                        state    <= S_NEXT;
`else
                        state    <= S_SQ_REQ;
`endif
                    end
                end
                S_SQ_REQ, S_MUL_REQ: begin
                    // The request is dropped right after accept so multmod does not restart.
                    if (mm_req_ready) begin
                        if (op_count != {CW{1'b1}}) op_count <= op_count + CW'(1);
                        state <= (state == S_SQ_REQ) ? S_SQ_WAIT : S_MUL_WAIT;
                    end
                end
                S_SQ_WAIT: begin
                    if (mm_res_valid) begin
                        acc   <= mm_Z;
                        state <= exp[idx] ? S_MUL_REQ : S_NEXT;
                    end
                end
                S_MUL_WAIT: begin
                    if (mm_res_valid) begin
                        acc   <= mm_Z;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
`ifdef POWMOD_SKIP_LEADING_ZEROS_EN
                    // The first set bit seeds acc with base instead of squaring 1.
                    if (lead && exp[idx]) begin
                        acc  <= base;
                        lead <= 1'b0;
                    end
                    if (idx == '0) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= (lead && !exp[idx]) ? S_NEXT : S_SQ_REQ;
                    end
`else
                    if (idx == '0) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= S_SQ_REQ;
                    end
`endif
                end
                S_DONE: begin
                    if (res_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (state == S_IDLE) && !rst;
    assign req_busy     = (state != S_IDLE) && (state != S_DONE);
    assign res_valid    = (state == S_DONE);
    assign Z            = acc;
    assign mm_X         = acc;
    assign mm_Y         = ((state == S_MUL_REQ) || (state == S_MUL_WAIT)) ? base : acc;
    assign mm_req_valid = (state == S_SQ_REQ) || (state == S_MUL_REQ);
    assign mm_res_ready = (state == S_SQ_WAIT) || (state == S_MUL_WAIT);

endmodule

// File: tb/tb_powmod_seq.sv
// tb/tb_powmod_seq.sv - randomized scoreboard bench for powmod_seq with a behavioural multmod model
module tb_powmod_seq;
    import x448_pkg::*;

    localparam int N  = 448;
    localparam int EW = 448;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  X;
    logic [EW-1:0] E;
    logic          req_valid;
    logic          req_ready;
    logic          req_busy;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  Z;
    logic [N-1:0]  mm_X;
    logic [N-1:0]  mm_Y;
    logic          mm_req_valid;
    logic          mm_req_ready;
    logic          mm_req_busy;
    logic          mm_res_valid;
    logic          mm_res_ready;
    logic [N-1:0]  mm_Z;
    logic [CW-1:0] op_count;

    powmod_seq #(.N(N), .EW(EW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .X(X), .E(E),
        .req_valid(req_valid), .req_ready(req_ready), .req_busy(req_busy),
        .res_valid(res_valid), .res_ready(res_ready), .Z(Z),
        .mm_X(mm_X), .mm_Y(mm_Y), .mm_req_valid(mm_req_valid), .mm_req_ready(mm_req_ready),
        .mm_req_busy(mm_req_busy), .mm_res_valid(mm_res_valid), .mm_res_ready(mm_res_ready),
        .mm_Z(mm_Z), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] z;
        int           ops;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cycles = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        return N'(p % {{N{1'b0}}, P448});
    endfunction

    // Right-to-left binary exponentiation, independent of the DUT's scan order.
    function automatic logic [N-1:0] ref_pow(input logic [N-1:0] x, input logic [EW-1:0] e);
        logic [N-1:0] r, b;
        r = N'(1);
        b = x;
        for (int i = 0; i < EW; i++) begin
            if (e[i]) r = mulmod(r, b);
            b = mulmod(b, b);
        end
        return r;
    endfunction

    function automatic int ref_ops(input logic [EW-1:0] e);
        int pc, msb;
        pc = 0;
        msb = -1;
        for (int i = 0; i < EW; i++) if (e[i]) begin pc++; msb = i; end
`ifdef POWMOD_SKIP_LEADING_ZEROS_EN
        return (msb < 0) ? 0 : msb + pc - 1;
`else
        return EW + pc;
`endif
    endfunction

    // Multmod model: stalls, captures operands at accept, returns the product after random latency.
    initial begin
        int mstate, scnt, lat;
        logic [N-1:0] a, b;
        logic seen;
        mm_req_ready = 1'b0; mm_req_busy = 1'b0; mm_res_valid = 1'b0; mm_Z = '0;
        mstate = 0; scnt = 0; lat = 0; seen = 1'b0; a = '0; b = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mm_req_ready = 1'b0; mm_req_busy = 1'b0; mm_res_valid = 1'b0;
                mstate = 0; scnt = 0; seen = 1'b0;
            end else begin
                case (mstate)
                    0: if (mm_req_valid) begin
                        if (!seen) begin a = mm_X; b = mm_Y; seen = 1'b1; end
                        else begin
                            chk("mm_X_stable", mm_X, a);
                            chk("mm_Y_stable", mm_Y, b);
                        end
                        if (scnt < stall_cycles) scnt++;
                        else begin mm_req_ready = 1'b1; mstate = 1; end
                    end
                    1: begin
                        mm_req_ready = 1'b0;
                        mm_req_busy = 1'b1;
                        chk("mm_req_valid_drop", N'(mm_req_valid), N'(0));
                        lat = $urandom_range(0, 2);
                        mstate = 2;
                    end
                    2: begin
                        chk("mm_X_hold", mm_X, a);
                        chk("mm_Y_hold", mm_Y, b);
                        if (lat > 0) lat--;
                        else begin
                            mm_Z = mulmod(a, b);
                            mm_res_valid = 1'b1;
                            mm_req_busy = 1'b0;
                            mstate = 3;
                        end
                    end
                    default: begin
                        mm_res_valid = 1'b0;
                        mstate = 0; scnt = 0; seen = 1'b0;
                    end
                endcase
            end
        end
    end

    // Monitor: each new result presentation is popped from the scoreboard and compared.
    initial begin
        logic prev;
        exp_t x;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b0;
            else begin
                if (res_valid && !prev) begin
                    if (exp_q.size() == 0) chk("unexpected_result", N'(1), N'(0));
                    else begin
                        x = exp_q.pop_front();
                        chk("Z", Z, x.z);
                        chk("op_count", N'(op_count), N'(x.ops));
                    end
                end
                prev = res_valid;
            end
        end
    end

    task automatic run_job(input logic [N-1:0] x, input logic [EW-1:0] e, input int hold);
        int t;
        exp_t item;
        logic [N-1:0] zh;
        t = 0;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        if (!req_ready) begin chk("req_ready_timeout", N'(0), N'(1)); return; end
        X = x; E = e; req_valid = 1'b1;
        item.z = ref_pow(x, e);
        item.ops = ref_ops(e);
        exp_q.push_back(item);
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (!res_valid && t < 40000) begin @(negedge clk); t++; end
        if (!res_valid) begin chk("result_timeout", N'(0), N'(1)); return; end
        zh = Z;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_res_valid", N'(res_valid), N'(1));
            chk("hold_Z", Z, zh);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_req_ready", N'(req_ready), N'(1));
        chk("idle_res_valid", N'(res_valid), N'(0));
    endtask

    function automatic logic [N-1:0] rand_wide();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [N-1:0] rx;
        int t;
        rst = 1'b1; X = '0; E = '0; req_valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", N'(req_ready), N'(0));
        chk("rst_req_busy", N'(req_busy), N'(0));
        chk("rst_res_valid", N'(res_valid), N'(0));
        chk("rst_op_count", N'(op_count), N'(0));
        chk("rst_Z", Z, N'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", N'(req_ready), N'(1));

        run_job(N'(2), EW'(0), 0);
        run_job(N'(2), EW'(10), 0);
        run_job(N'(2), EW'(P448 - N'(2)), 0);
        chk("inverse_of_2", mulmod(Z, N'(2)), N'(1));
        run_job(P448 - N'(1), EW'(2), 50);

        stall_cycles = 20;
        run_job(N'(3), EW'(5), 0);
        stall_cycles = 0;

        for (int k = 0; k < 2; k++) begin
            rx = rand_wide();
            if (rx >= P448) rx = rx - P448;
            run_job(rx, (k == 0) ? rand_wide() : EW'($urandom_range(0, 65535)), $urandom_range(0, 3));
        end

        // Abort a long job once 100 ops have been issued.
        X = N'(3); E = EW'(P448 - N'(2)); req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        t = 0;
        while (op_count < CW'(100) && t < 5000) begin @(negedge clk); t++; end
        chk("reached_100_ops", N'(op_count >= CW'(100)), N'(1));
        #2 rst = 1'b1;
        #1;
        chk("abort_req_ready", N'(req_ready), N'(0));
        chk("abort_req_busy", N'(req_busy), N'(0));
        chk("abort_res_valid", N'(res_valid), N'(0));
        chk("abort_Z", Z, N'(0));
        chk("abort_mm_X", mm_X, N'(0));
        chk("abort_mm_Y", mm_Y, N'(0));
        chk("abort_mm_req_valid", N'(mm_req_valid), N'(0));
        chk("abort_mm_res_ready", N'(mm_res_ready), N'(0));
        chk("abort_op_count", N'(op_count), N'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_job(N'(3), EW'(5), 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", N'(exp_q.size()), N'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
